// File: rtl/frame_read_ctrl.sv
// Frame readout sequencer: VSYNC delay, per-row HSYNC gap, then one even/odd pixel-pair address per cycle.
// Optional macro ROW_FLIP_EN reads memory rows bottom-up while `row` still counts upward.
module frame_read_ctrl #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int START_DELAY  = 100,
    parameter int HSYNC_DELAY  = 160,
    parameter int ADDR_WIDTH   = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] rd_addr_even,
    output logic [ADDR_WIDTH-1:0] rd_addr_odd,
    output logic                  rd_valid,
    output logic                  vertical_Pulse,
    output logic                  horizontal_Pulse,
    output logic [9:0]            row,
    output logic [10:0]           column,
    output logic                  busy,
    output logic                  done_Flag,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        VSYNC = 2'b01,
        HSYNC = 2'b10,
        DATA  = 2'b11
    } state_t;

    localparam int MAX_DELAY = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] HSYNC_LAST = CNT_W'(HSYNC_DELAY - 1);
    localparam logic [10:0]      LAST_COL   = 11'(IMAGE_WIDTH - 2);
    localparam logic [9:0]       LAST_ROW   = 10'(IMAGE_HEIGHT - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [9:0]        row_next;
    logic [10:0]       col_next;
    logic              done_next;
    logic [9:0]        phys_row;
    logic [ADDR_WIDTH-1:0] pair_base;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            row       <= '0;
            column    <= '0;
            done_Flag <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            row       <= row_next;
            column    <= col_next;
            done_Flag <= done_next;
        end
    end

    // Handshake: rd_valid qualifies the address pair; stall is the inverted ready,
    // and a pair is consumed on every DATA cycle with stall=0 (exactly when rd_valid=1).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        row_next   = row;
        col_next   = column;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                row_next = '0;
                col_next = '0;
                if (start) state_next = VSYNC;
            end
            VSYNC: begin
                if (cnt == VSYNC_LAST) begin
                    cnt_next   = '0;
                    state_next = HSYNC;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HSYNC: begin
                if (cnt == HSYNC_LAST) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (!stall) begin
                    if (column == LAST_COL) begin
                        col_next = '0;
                        if (row == LAST_ROW) begin
                            // Counters return to zero so IDLE outputs are all-zero.
                            row_next   = '0;
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            row_next   = row + 10'd1;
                            state_next = HSYNC;
                        end
                    end else begin
                        col_next = column + 11'd2;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
`ifdef ROW_FLIP_EN
        phys_row = LAST_ROW - row;
`else
        phys_row = row;
`endif
        pair_base = ADDR_WIDTH'(phys_row) * ADDR_WIDTH'(IMAGE_WIDTH) + ADDR_WIDTH'(column);
    end

    // Addresses are forced to zero outside DATA so an idle or resetting block drives no stray index.
    assign rd_addr_even     = (state == DATA) ? pair_base : '0;
    assign rd_addr_odd      = (state == DATA) ? pair_base + ADDR_WIDTH'(1) : '0;
    assign rd_valid         = (state == DATA) & ~stall;
    assign horizontal_Pulse = rd_valid;
    assign vertical_Pulse   = (state == VSYNC);
    assign busy             = (state != IDLE);
    assign state_dbg        = state;

endmodule

// File: doc/frame_read_ctrl.md
# frame_read_ctrl

Sequencer for the image-readout and threshold datapath. It runs one frame on a `start` pulse: a start-up delay, then per-row horizontal-sync gaps, then the data phase. During the data phase it steps row and column counters and issues one even/odd pixel-pair address per cycle to the pixel memory. It drives the vertical and horizontal sync pulses and the frame `done_Flag` seen by the downstream image writer. A `stall` input lets the writer back-pressure the data phase.

## Interface
- `IMAGE_WIDTH`, 768, pixels per row; must be even.
- `IMAGE_HEIGHT`, 512, rows per frame.
- `START_DELAY`, 100, cycles spent in VSYNC; ≥1.
- `HSYNC_DELAY`, 160, cycles spent in HSYNC before each row; ≥1.
- `ADDR_WIDTH`, 19, pixel-index address width; must hold IMAGE_WIDTH*IMAGE_HEIGHT-1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `stall`  in  1  downstream back-pressure; honoured only in DATA.
- `rd_addr_even`  out  ADDR_WIDTH  pixel index of the even pixel of the current pair.
- `rd_addr_odd`  out  ADDR_WIDTH  `rd_addr_even`+1.
- `rd_valid`  out  1  addresses valid this cycle.
- `vertical_Pulse`  out  1  high while in VSYNC.
- `horizontal_Pulse`  out  1  equal to `rd_valid`; marks active line data.
- `row`  out  10  logical output row, 0..IMAGE_HEIGHT-1.
- `column`  out  11  even column of the current pair, 0..IMAGE_WIDTH-2.
- `busy`  out  1  state ≠ IDLE.
- `done_Flag`  out  1  one-cycle pulse after the last pair of a frame.

## Operation
- States:
  - IDLE (00), VSYNC (01), HSYNC (10), DATA (11); 2-bit registered state.
- IDLE:
  - `start`=1 → VSYNC.
  - Clear `row`, `column` and the delay counter.
- VSYNC:
  - Count START_DELAY cycles, then → HSYNC.
  - `stall` is ignored.
- HSYNC:
  - Count HSYNC_DELAY cycles, then → DATA.
  - `stall` is ignored.
- DATA:
  - Each cycle with `stall`=0 is one issued pair, and `column` advances by 2.
  - After the pair at `column`=IMAGE_WIDTH-2:
    - If `row`<IMAGE_HEIGHT-1: `row`+1, `column`=0, → HSYNC.
    - If `row`=IMAGE_HEIGHT-1: → IDLE, `done_Flag` asserted the next cycle.
  - With `stall`=1: counters and state hold, `rd_valid`=0.
- Address generation:
  - `rd_addr_even` = phys_row*IMAGE_WIDTH + `column`, computed at ADDR_WIDTH bits with no overflow for legal parameters.
  - phys_row = `row`, or the flipped order below when the configuration macro is defined.
- Outputs combinational from state and stall:
  - `rd_valid` = (state==DATA) & ~`stall`.
  - `vertical_Pulse` = (state==VSYNC).
  - `busy` = (state≠IDLE).
- `start` while busy is ignored; no queuing.
- A new frame may start in the same cycle `done_Flag` is high, since state is IDLE in that cycle.
- Reset (`reset`=0 at a clock edge, from any state):
  - state=IDLE; all counters 0.
  - `done_Flag`=0; all outputs 0.
  - A mid-frame reset aborts the frame with no `done_Flag`.

## Timing
- Cycle 0 is the cycle with `start`=1 in IDLE.
  - VSYNC occupies cycles 1..START_DELAY.
  - The first `rd_valid` is at cycle 1+START_DELAY+HSYNC_DELAY.
- Unstalled frame:
  - Length is START_DELAY + IMAGE_HEIGHT*(HSYNC_DELAY + IMAGE_WIDTH/2) cycles.
  - `done_Flag` is high at cycle 1 + that length.
  - Each stalled DATA cycle adds exactly one cycle.
- Address latency: 0 cycles. Address outputs are valid in the same cycle as `rd_valid`; the memory read latency belongs to the datapath.
- `done_Flag` is registered: a single-cycle pulse.

## Configuration
- `ROW_FLIP_EN`:
  - Defined: phys_row = IMAGE_HEIGHT-1-`row`, so the frame reads memory bottom-up, matching bottom-up stored bitmaps. `row` still counts 0 upward.
  - Undefined: phys_row = `row`, a top-down read.

## Test plan
- All tests use W=8, H=4, START_DELAY=3, HSYNC_DELAY=2.
- Basic frame:
  - Stimulus: `start` at cycle 0, macro undefined.
  - `vertical_Pulse` high in cycles 1–3.
  - `rd_valid` high in cycles 6–9, 12–15, 18–21 and 24–27.
  - First pair is 0/1; last pair is 30/31.
  - `done_Flag` is high only at cycle 28; `busy` is low from cycle 28.
- `ROW_FLIP_EN` defined, same stimulus:
  - First pair is 24/25; the pair at cycle 12 is 16/17; last pair is 6/7.
  - `row` outputs 0,1,2,3 in order.
- Stall:
  - Stimulus: `stall`=1 during cycles 13–15.
  - `rd_valid`=0 in cycles 13–15, and `column` holds at 2 during them.
  - `done_Flag` moves to cycle 31.
  - `stall` asserted during VSYNC or HSYNC has no effect.
- Reset mid-frame:
  - Stimulus: `reset`=0 at cycle 14.
  - From cycle 15: all outputs 0, state IDLE, no `done_Flag`.
  - A `start` at cycle 20 reproduces the basic-frame timing offset by 20.
- Ignored start:
  - Stimulus: `start` pulses at cycles 5 and 16.
  - Timing is identical to the basic frame.
  - A `start` held high at cycle 28 begins a new frame, with VSYNC in cycles 29–31.
